// File: rtl/jtframe_i2s_tx.sv
// I2S transmitter: divides clk into BCLK/LRCLK and serialises one buffered
// stereo pair per 64-BCLK frame, MSB one BCLK after each LRCLK edge.
module jtframe_i2s_tx #(
  parameter int DIV = 8,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample,
  input  logic [W-1:0] snd_left,
  input  logic [W-1:0] snd_right,
  input  logic         mute,
  output logic         i2s_bclk,
  output logic         i2s_lrclk,
  output logic         i2s_data,
  output logic         underrun,
  output logic         overrun
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] div_cnt;
  logic [5:0]    b;
  logic [5:0]    b_next;
  logic          wrap;
  logic          fall;
  logic          frame_load;
  logic [W-1:0]  pend_l;
  logic [W-1:0]  pend_r;
  logic          pend_valid;
  logic [W-1:0]  held_l;
  logic [W-1:0]  held_r;
  logic [W-1:0]  word;
  logic [31:0]   slot;
  logic [4:0]    idx;

  assign wrap       = div_cnt == CW'(DIV - 1);
  assign fall       = wrap && i2s_bclk;
  assign b_next     = b + 6'd1;
  assign frame_load = fall && (b_next == 6'd0);

  // The word is left-justified in a 32-bit slot so slot position p maps to
  // bit 32-p (= ~(p-1)); p=0 and p>W land on the zero padding below the LSB.
  assign word = b_next[5] ? held_r : held_l;
  assign slot = 32'(word) << (32 - W);
  assign idx  = b_next[4:0] - 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      b          <= 6'd63;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_data   <= 1'b0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      pend_valid <= 1'b0;
      held_l     <= '0;
      held_r     <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle; later assignments in
      // this block win, so a pulse lasts exactly one clk.
      underrun <= 1'b0;
      overrun  <= 1'b0;

      div_cnt <= wrap ? '0 : div_cnt + CW'(1);
      if (wrap) i2s_bclk <= ~i2s_bclk;

      if (fall) begin
        b         <= b_next;
        i2s_lrclk <= b_next[5];
        i2s_data  <= ~mute & slot[~idx];
      end

      if (frame_load) begin
        if (pend_valid) begin
          held_l <= pend_l;
          held_r <= pend_r;
        end else begin
          underrun <= 1'b1;
        end
      end

      // A strobe coinciding with a frame load refills pending after the
      // load has taken the old contents, so nothing is lost.
      if (sample) begin
        pend_l     <= snd_left;
        pend_r     <= snd_right;
        pend_valid <= 1'b1;
        overrun    <= pend_valid & ~frame_load;
      end else if (frame_load) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
